tape_ctrl: RTL and testbench

- Sequencer for the data-tape datapath: holds the current cell in a cache register and owns the head pointer.
- INC/DEC/LD complete in one cycle on the cached cell. MVR/MVL run a multi-cycle write-back/refill sequence against a synchronous single-port data memory.
- Sits between the instruction decoder (valid/ready command port) and the data memory. It stalls the decoder while a tape move is in flight.

---
 rtl/tape_ctrl.sv | 148 ++++++++++++++
 tb/tb_tape_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_ctrl.sv
// ============================================================================
// Module   : tape_ctrl
// Brief    : Tape sequencer: cached current cell, head pointer, write-back/refill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tape_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] cell_q,
  output logic [ADDR_W-1:0] head_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] c_OP_INC   = 3'd1;
  localparam logic [2:0] c_OP_DEC   = 3'd2;
  localparam logic [2:0] c_OP_MVR   = 3'd3;
  localparam logic [2:0] c_OP_MVL   = 3'd4;
  localparam logic [2:0] c_OP_LD    = 3'd5;
  localparam logic [2:0] c_OP_FLUSH = 3'd6;

  localparam logic [ADDR_W-1:0] c_ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] c_ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_cell;
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_wb_addr;
  logic              r_dirty;
  logic              r_flush;
  logic              w_accept;

  assign w_accept  = cmd_valid && (r_state == IDLE);
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign cell_q    = r_cell;
  assign head_addr = r_head;
  assign mem_wdata = r_cell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory strobes decode from state alone so reset drops mem_we at once.
  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_addr    = r_head;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_op == c_OP_MVR || cmd_op == c_OP_MVL) begin
            w_state_nxt = r_dirty ? WB : RD;
          end else if (cmd_op == c_OP_FLUSH && r_dirty) begin
            w_state_nxt = WB;
          end
        end
      end
      WB: begin
        mem_we      = 1'b1;
        mem_addr    = r_wb_addr;
        w_state_nxt = r_flush ? IDLE : RD;
      end
      RD:      w_state_nxt = FILL;
      FILL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cell    <= '0;
      r_head    <= '0;
      r_wb_addr <= '0;
      r_dirty   <= 1'b1;
      r_flush   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              c_OP_INC: begin
                r_cell  <= r_cell + c_ONE_D;
                r_dirty <= 1'b1;
              end
              c_OP_DEC: begin
                r_cell  <= r_cell - c_ONE_D;
                r_dirty <= 1'b1;
              end
              c_OP_LD: begin
                r_cell  <= cmd_data;
                r_dirty <= 1'b1;
              end
              c_OP_MVR: begin
                r_wb_addr <= r_head;
                r_head    <= r_head + c_ONE_A;
                r_flush   <= 1'b0;
              end
              c_OP_MVL: begin
                r_wb_addr <= r_head;
                r_head    <= r_head - c_ONE_A;
                r_flush   <= 1'b0;
              end
              c_OP_FLUSH: begin
                r_wb_addr <= r_head;
                r_flush   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        WB:   r_dirty <= 1'b0;
        FILL: begin
          r_cell  <= mem_rdata;
          r_dirty <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tape_ctrl.sv
// ============================================================================
// Module   : tb_tape_ctrl
// Brief    : Self-checking bench for tape_ctrl against a cell/head/memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tape_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] cell_q;
  logic [ADDR_W-1:0] head_addr;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  tape_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cell_q    (cell_q),
    .head_addr (head_addr),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port data memory with a bench-side preload port.
  logic [DATA_W-1:0] tb_mem [DEPTH];
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    else if (pl_we) tb_mem[pl_addr] <= pl_data;
    mem_rdata <= tb_mem[mem_addr];
  end

  // Reference model: tape contents, cached cell, head, dirty flag.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] m_cell;
  int                m_head;
  logic              m_dirty;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic preload(input int addr, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = addr[ADDR_W-1:0]; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
    ref_mem[addr] = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    m_cell = '0; m_head = 0; m_dirty = 1'b1;
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: we=%b busy=%b ready=%b, expected 0 0 1", mem_we, busy, cmd_ready);
    end
    n_checks++;
    if (cell_q !== 8'h00 || head_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: cell=%h head=%0d, expected 00 0", cell_q, head_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one command from IDLE, updates the model, and checks every busy cycle.
  task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] d);
    int exp_cyc, exp_wr, new_head, old_head, n, nwr;
    logic [DATA_W-1:0] old_cell;
    old_head = m_head; old_cell = m_cell; new_head = m_head;
    exp_cyc = 0; exp_wr = 0;
    case (op)
      3'd1: begin m_cell = m_cell + 8'd1; m_dirty = 1'b1; end
      3'd2: begin m_cell = m_cell - 8'd1; m_dirty = 1'b1; end
      3'd5: begin m_cell = d; m_dirty = 1'b1; end
      3'd3, 3'd4: begin
        new_head = (op == 3'd3) ? (m_head + 1) % DEPTH : (m_head + DEPTH - 1) % DEPTH;
        exp_cyc  = m_dirty ? 3 : 2;
        exp_wr   = m_dirty ? 1 : 0;
        if (m_dirty) ref_mem[m_head] = m_cell;
        m_head = new_head; m_cell = ref_mem[new_head]; m_dirty = 1'b0;
      end
      3'd6: if (m_dirty) begin
        exp_cyc = 1; exp_wr = 1; ref_mem[m_head] = m_cell; m_dirty = 1'b0;
      end
      default: ;
    endcase
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_idle: op=%0d ready=%b, expected 1", op, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0;
    n = 0; nwr = 0;
    while (busy === 1'b1 && n < 8) begin
      n_checks++;
      if (cmd_ready !== 1'b0 || head_addr !== new_head[ADDR_W-1:0]) begin
        n_fail++;
        $display("FAIL busy_cycle: op=%0d ready=%b head=%0d, expected 0 %0d", op, cmd_ready, head_addr, new_head);
      end
      n_checks++;
      if (mem_we === 1'b1) begin
        nwr++;
        if (mem_addr !== old_head[ADDR_W-1:0] || mem_wdata !== old_cell) begin
          n_fail++;
          $display("FAIL wb_write: addr=%0d data=%h, expected %0d %h", mem_addr, mem_wdata, old_head, old_cell);
        end
      end else if (mem_addr !== new_head[ADDR_W-1:0]) begin
        n_fail++;
        $display("FAIL rd_addr: addr=%0d, expected %0d", mem_addr, new_head);
      end
      n++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (n != exp_cyc || nwr != exp_wr) begin
      n_fail++;
      $display("FAIL latency: op=%0d busy=%0d writes=%0d, expected %0d %0d", op, n, nwr, exp_cyc, exp_wr);
    end
    n_checks++;
    if (cell_q !== m_cell || head_addr !== m_head[ADDR_W-1:0] || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL result: op=%0d cell=%h head=%0d we=%b, expected %h %0d 0", op, cell_q, head_addr, mem_we, m_cell, m_head);
    end
  endtask

  task automatic test_arith;
    for (int i = 0; i < 3; i++) issue(3'd1, 8'h00);
    test_reset();
    issue(3'd2, 8'h00);
    issue(3'd5, 8'h7F);
    issue(3'd1, 8'h00);
    n_checks++;
    if (cell_q !== 8'h80) begin
      n_fail++;
      $display("FAIL ld_inc: cell=%h, expected 80", cell_q);
    end
  endtask

  task automatic test_move_dirty;
    preload(1, 8'h5A);
    test_reset();
    for (int i = 0; i < 3; i++) issue(3'd1, 8'h00);
    issue(3'd3, 8'h00);
    n_checks++;
    if (cell_q !== 8'h5A || head_addr !== 10'd1 || tb_mem[0] !== 8'h03) begin
      n_fail++;
      $display("FAIL mvr_dirty: cell=%h head=%0d mem0=%h, expected 5a 1 03", cell_q, head_addr, tb_mem[0]);
    end
  endtask

  task automatic test_wrap;
    preload(1023, 8'h11);
    test_reset();
    issue(3'd6, 8'h00);
    issue(3'd4, 8'h00);
    n_checks++;
    if (cell_q !== 8'h11 || head_addr !== 10'd1023) begin
      n_fail++;
      $display("FAIL mvl_wrap: cell=%h head=%0d, expected 11 1023", cell_q, head_addr);
    end
    issue(3'd3, 8'h00);
  endtask

  task automatic test_flush;
    test_reset();
    for (int i = 0; i < 5; i++) issue(3'd3, 8'h00);
    issue(3'd5, 8'h42);
    issue(3'd6, 8'h00);
    issue(3'd6, 8'h00);
    n_checks++;
    if (tb_mem[5] !== 8'h42) begin
      n_fail++;
      $display("FAIL flush_mem: mem5=%h, expected 42", tb_mem[5]);
    end
  endtask

  task automatic test_reset_mid;
    test_reset();
    issue(3'd1, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0;
    ref_mem[0] = m_cell;
    @(posedge clk);
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 10'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd: we=%b addr=%0d busy=%b, expected 0 1 1", mem_we, mem_addr, busy);
    end
    rst_n = 1'b0;
    #1;
    m_cell = '0; m_head = 0; m_dirty = 1'b1;
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || head_addr !== '0 || cell_q !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b busy=%b head=%0d cell=%h, expected 0 0 0 00", mem_we, busy, head_addr, cell_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd6, 8'h00);
    n_checks++;
    if (tb_mem[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_flush: mem0=%h, expected 00", tb_mem[0]);
    end
  endtask

  task automatic test_random;
    logic [2:0] op;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, 8'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      tb_mem[a]  = 8'($urandom);
      ref_mem[a] = tb_mem[a];
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_arith();
    test_move_dirty();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
